decode_cycle: RTL

Second stage of the five-stage RV32I pipeline. It takes the instruction, PC and PC+4 from the IF/ID register driven by `fetch_cycle`. It decodes control signals, extends the immediate, and reads the 32×32 register file; the write-back stage writes that file through a dedicated write port. All results are registered into the ID/EX pipeline register that feeds `execute_cycle`.

---
 rtl/decode_cycle.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, 32x32 register file
// with write-through bypass, and the ID/EX pipeline register.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} imm_src_e;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_funct7b5;

  assign w_opcode   = InstrD[6:0];
  assign w_rd       = InstrD[11:7];
  assign w_funct3   = InstrD[14:12];
  assign w_rs1      = InstrD[19:15];
  assign w_rs2      = InstrD[24:20];
  assign w_funct7b5 = InstrD[30];

  logic       w_reg_write;
  logic       w_alu_src;
  logic       w_mem_write;
  logic       w_result_src;
  logic       w_branch;
  imm_src_e   w_imm_src;
  logic [1:0] w_alu_op;

  // Unknown opcodes decode to a bubble: every control bit stays 0.
  always_comb begin
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 1'b0;
    w_branch     = 1'b0;
    w_imm_src    = IMM_I;
    w_alu_op     = 2'b00;
    case (w_opcode)
      7'b0000011: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 1'b1;
      end
      7'b0100011: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm_src   = IMM_S;
      end
      7'b0110011: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      7'b0010011: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b10;
      end
      7'b1100011: begin
        w_branch  = 1'b1;
        w_imm_src = IMM_B;
        w_alu_op  = 2'b01;
      end
      default: ;
    endcase
  end

  logic [2:0] w_alu_ctrl;

  always_comb begin
    w_alu_ctrl = 3'b000;
    case (w_alu_op)
      2'b01: w_alu_ctrl = 3'b001;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_alu_ctrl = (w_opcode[5] & w_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_ctrl = 3'b101;
          3'b110:  w_alu_ctrl = 3'b011;
          3'b111:  w_alu_ctrl = 3'b010;
          default: w_alu_ctrl = 3'b000;
        endcase
      end
      default: w_alu_ctrl = 3'b000;
    endcase
  end

  logic [31:0] w_imm_ext;

  always_comb begin
    w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    case (w_imm_src)
      IMM_S:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  logic [31:0] r_regs [32];
  logic        w_wb_en;

  assign w_wb_en = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[RDW] <= ResultW;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees a stale value.
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  assign w_rd1 = (w_rs1 == 5'd0) ? 32'd0 :
                 (w_wb_en && (RDW == w_rs1)) ? ResultW : r_regs[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? 32'd0 :
                 (w_wb_en && (RDW == w_rs2)) ? ResultW : r_regs[w_rs2];

  logic        r_reg_write;
  logic        r_alu_src;
  logic        r_mem_write;
  logic        r_result_src;
  logic        r_branch;
  logic [2:0]  r_alu_ctrl;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_ctrl   <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rd         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
    end else begin
      r_reg_write  <= w_reg_write;
      r_alu_src    <= w_alu_src;
      r_mem_write  <= w_mem_write;
      r_result_src <= w_result_src;
      r_branch     <= w_branch;
      r_alu_ctrl   <= w_alu_ctrl;
      r_rd1        <= w_rd1;
      r_rd2        <= w_rd2;
      r_imm        <= w_imm_ext;
      r_rd         <= w_rd;
      r_rs1        <= w_rs1;
      r_rs2        <= w_rs2;
      r_pc         <= PCD;
      r_pc_plus4   <= PCPlus4D;
    end
  end

  assign RegWriteE   = r_reg_write;
  assign ALUSrcE     = r_alu_src;
  assign MemWriteE   = r_mem_write;
  assign ResultSrcE  = r_result_src;
  assign BranchE     = r_branch;
  assign ALUControlE = r_alu_ctrl;
  assign RD1_E       = r_rd1;
  assign RD2_E       = r_rd2;
  assign Imm_Ext_E   = r_imm;
  assign RD_E        = r_rd;
  assign RS1_E       = r_rs1;
  assign RS2_E       = r_rs2;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pc_plus4;

endmodule
